mesh_phase_ctrl: RTL and testbench

MESH_PHASE_CTRL -- requirements
Module: mesh_phase_ctrl

---
 rtl/mesh_phase_ctrl_if.sv | 42 ++++
 rtl/mesh_phase_ctrl.sv | 126 ++++++++++++
 tb/tb_mesh_phase_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mesh_phase_ctrl_if.sv
// Control bus between the shearsort phase controller and its requester/PE array.
// The slave side is the controller; the master side issues start/abort and
// consumes the phase, parity and commit strobes.
interface mesh_phase_ctrl_if #(
  parameter int LOG_N = 2
);

  logic             i_start;
  logic             i_abort;
  logic             o_busy;
  logic             o_done;
  logic             o_phase;
  logic             o_parity;
  logic             o_cmp_en;
  logic             o_commit;
  logic [LOG_N:0]   o_iter;

  modport master (
    output i_start,
    output i_abort,
    input  o_busy,
    input  o_done,
    input  o_phase,
    input  o_parity,
    input  o_cmp_en,
    input  o_commit,
    input  o_iter
  );

  modport slave (
    input  i_start,
    input  i_abort,
    output o_busy,
    output o_done,
    output o_phase,
    output o_parity,
    output o_cmp_en,
    output o_commit,
    output o_iter
  );

endinterface

// File: rtl/mesh_phase_ctrl.sv
// Shearsort phase sequencer for an N x N mesh of compare-exchange PEs.
// A pass alternates row and column phases (LOG_N+1 rows, LOG_N columns),
// each phase running N odd/even steps of SORT_CYCLES clocks. Every output
// is a register loaded from the next-state values, so the PE array sees
// glitch-free strobes aligned with the state they describe.
module mesh_phase_ctrl #(
  parameter int N           = 4,
  parameter int LOG_N       = 2,
  parameter int SORT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  mesh_phase_ctrl_if.slave  bus
);

  localparam int CYC_W = $clog2(SORT_CYCLES + 1);

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(SORT_CYCLES - 1);
  localparam logic [LOG_N-1:0] STEP_LAST = LOG_N'(N - 1);
  localparam logic [LOG_N:0]   ITER_LAST = (LOG_N + 1)'(LOG_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    COL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [CYC_W-1:0] cyc_q, cyc_n;
  logic [LOG_N-1:0] step_q, step_n;
  logic [LOG_N:0]   iter_q, iter_n;

  logic busy_q, done_q, phase_q, parity_q, cmp_en_q, commit_q;

  // Next-state and counter advance; an abort or step overflow both land on clean counters.
  always_comb begin
    state_n = state_q;
    cyc_n   = cyc_q;
    step_n  = step_q;
    iter_n  = iter_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_n = ROW;
          cyc_n   = '0;
          step_n  = '0;
          iter_n  = '0;
        end
      end
      ROW, COL: begin
        if (bus.i_abort) begin
          state_n = IDLE;
          cyc_n   = '0;
          step_n  = '0;
          iter_n  = '0;
        end else if (cyc_q == CYC_LAST) begin
          cyc_n = '0;
          if (step_q == STEP_LAST) begin
            step_n = '0;
            if (state_q == ROW) begin
              if (iter_q == ITER_LAST) begin
                state_n = DONE;
                iter_n  = '0;
              end else begin
                state_n = COL;
              end
            end else begin
              state_n = ROW;
              iter_n  = iter_q + (LOG_N + 1)'(1);
            end
          end else begin
            step_n = step_q + LOG_N'(1);
          end
        end else begin
          cyc_n = cyc_q + CYC_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cyc_n   = '0;
        step_n  = '0;
        iter_n  = '0;
      end
    endcase
  end

  // State, counters and output registers; outputs are decoded from the values being loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      step_q   <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      phase_q  <= 1'b0;
      parity_q <= 1'b0;
      cmp_en_q <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      cyc_q    <= cyc_n;
      step_q   <= step_n;
      iter_q   <= iter_n;
      busy_q   <= (state_n == ROW) || (state_n == COL);
      done_q   <= (state_n == DONE);
      phase_q  <= (state_n == COL);
      parity_q <= ((state_n == ROW) || (state_n == COL)) && step_n[0];
      cmp_en_q <= (state_n == ROW) || (state_n == COL);
      commit_q <= ((state_n == ROW) || (state_n == COL)) && (cyc_n == CYC_LAST);
    end
  end

  assign bus.o_busy   = busy_q;
  assign bus.o_done   = done_q;
  assign bus.o_phase  = phase_q;
  assign bus.o_parity = parity_q;
  assign bus.o_cmp_en = cmp_en_q;
  assign bus.o_commit = commit_q;
  assign bus.o_iter   = iter_q;

endmodule

// File: tb/tb_mesh_phase_ctrl.sv
// Bench for mesh_phase_ctrl: two instances (SORT_CYCLES 1 and 3) share one
// stimulus stream and are compared cycle by cycle against a pass model that
// derives phase/step/parity/iteration arithmetically from the busy-cycle index.
module tb_mesh_phase_ctrl;

  localparam int N     = 4;
  localparam int LOG_N = 2;
  localparam int SC_A  = 1;
  localparam int SC_B  = 3;

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  logic rst;

  mesh_phase_ctrl_if #(.LOG_N(LOG_N)) ifA ();
  mesh_phase_ctrl_if #(.LOG_N(LOG_N)) ifB ();

  mesh_phase_ctrl #(.N(N), .LOG_N(LOG_N), .SORT_CYCLES(SC_A)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA.slave)
  );

  mesh_phase_ctrl #(.N(N), .LOG_N(LOG_N), .SORT_CYCLES(SC_B)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB.slave)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;

  int modelMode [2];
  int modelK    [2];
  int busyCnt   [2];
  int commitCnt [2];
  int doneCnt   [2];

  function automatic int scOf(input int idx);
    return (idx == 0) ? SC_A : SC_B;
  endfunction

  function automatic int passLen(input int idx);
    return (2 * LOG_N + 1) * N * scOf(idx);
  endfunction

  // Expected {busy,done,phase,parity,cmp_en,commit,iter[2:0]} for a model.
  function automatic logic [15:0] expectOut(input int idx);
    logic [15:0] e;
    int sc, stepGlobal, phaseIdx, step;
    e  = '0;
    sc = scOf(idx);
    if (modelMode[idx] == M_BUSY) begin
      stepGlobal = modelK[idx] / sc;
      phaseIdx   = stepGlobal / N;
      step       = stepGlobal % N;
      e[8]   = 1'b1;
      e[6]   = (phaseIdx % 2) == 1;
      e[5]   = (step % 2) == 1;
      e[4]   = 1'b1;
      e[3]   = (modelK[idx] % sc) == (sc - 1);
      e[2:0] = 3'(phaseIdx / 2);
    end else if (modelMode[idx] == M_DONE) begin
      e[7] = 1'b1;
    end
    return e;
  endfunction

  task automatic modelStep(input int idx, input logic r, input logic s, input logic a);
    if (r) begin
      modelMode[idx] = M_IDLE;
      modelK[idx]    = 0;
    end else begin
      case (modelMode[idx])
        M_IDLE: if (s) begin
          modelMode[idx] = M_BUSY;
          modelK[idx]    = 0;
        end
        M_BUSY: begin
          if (a) begin
            modelMode[idx] = M_IDLE;
            modelK[idx]    = 0;
          end else begin
            modelK[idx] = modelK[idx] + 1;
            if (modelK[idx] == passLen(idx)) modelMode[idx] = M_DONE;
          end
        end
        default: modelMode[idx] = M_IDLE;
      endcase
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare both DUTs.
  task automatic applyStimulus(input logic r, input logic s, input logic a);
    logic [15:0] obsA, obsB;
    rst         = r;
    ifA.i_start = s;
    ifA.i_abort = a;
    ifB.i_start = s;
    ifB.i_abort = a;
    @(posedge clk);
    modelStep(0, r, s, a);
    modelStep(1, r, s, a);
    #1;
    obsA = {7'd0, ifA.o_busy, ifA.o_done, ifA.o_phase, ifA.o_parity,
            ifA.o_cmp_en, ifA.o_commit, ifA.o_iter};
    obsB = {7'd0, ifB.o_busy, ifB.o_done, ifB.o_phase, ifB.o_parity,
            ifB.o_cmp_en, ifB.o_commit, ifB.o_iter};
    checkOutput("outA", obsA, expectOut(0));
    checkOutput("outB", obsB, expectOut(1));
    busyCnt[0]   += int'(ifA.o_busy);
    commitCnt[0] += int'(ifA.o_commit);
    doneCnt[0]   += int'(ifA.o_done);
    busyCnt[1]   += int'(ifB.o_busy);
    commitCnt[1] += int'(ifB.o_commit);
    doneCnt[1]   += int'(ifB.o_done);
  endtask

  task automatic clearCounts();
    for (int i = 0; i < 2; i++) begin
      busyCnt[i]   = 0;
      commitCnt[i] = 0;
      doneCnt[i]   = 0;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      modelMode[i] = M_IDLE;
      modelK[i]    = 0;
    end
    clearCounts();

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 0);
    idleCycles(2);

    $display("[TB] single pass");
    clearCounts();
    applyStimulus(1'b0, 1'b1, 1'b0);
    idleCycles(69);
    checkOutput("passBusyA",   16'(busyCnt[0]),   16'd20);
    checkOutput("passCommitA", 16'(commitCnt[0]), 16'd20);
    checkOutput("passDoneA",   16'(doneCnt[0]),   16'd1);
    checkOutput("passBusyB",   16'(busyCnt[1]),   16'd60);
    checkOutput("passCommitB", 16'(commitCnt[1]), 16'd20);
    checkOutput("passDoneB",   16'(doneCnt[1]),   16'd1);

    $display("[TB] abort at busy cycle 7");
    clearCounts();
    applyStimulus(1'b0, 1'b1, 1'b0);
    idleCycles(7);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleCycles(4);
    checkOutput("abortBusyA", 16'(busyCnt[0]), 16'd8);
    checkOutput("abortDoneA", 16'(doneCnt[0]), 16'd0);
    checkOutput("abortDoneB", 16'(doneCnt[1]), 16'd0);
    clearCounts();
    applyStimulus(1'b0, 1'b1, 1'b0);
    idleCycles(69);
    checkOutput("reBusyA", 16'(busyCnt[0]), 16'd20);
    checkOutput("reDoneA", 16'(doneCnt[0]), 16'd1);

    $display("[TB] reset mid-pass");
    clearCounts();
    applyStimulus(1'b0, 1'b1, 1'b0);
    idleCycles(10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    idleCycles(3);
    checkOutput("rstBusyA", 16'(busyCnt[0]), 16'd11);
    checkOutput("rstDoneA", 16'(doneCnt[0]), 16'd0);
    checkOutput("rstDoneB", 16'(doneCnt[1]), 16'd0);
    clearCounts();
    applyStimulus(1'b0, 1'b1, 1'b0);
    idleCycles(69);
    checkOutput("postRstBusyA", 16'(busyCnt[0]), 16'd20);
    checkOutput("postRstBusyB", 16'(busyCnt[1]), 16'd60);

    $display("[TB] start held high");
    clearCounts();
    for (int i = 0; i < 150; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("heldDoneA", 16'(doneCnt[0]), 16'd6);
    checkOutput("heldDoneB", 16'(doneCnt[1]), 16'd2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(2);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
